// File: rtl/foc_xform_sequencer.sv
// FOC transform sequencer: snapshots currents/angle per trigger, waits the
// clarke and park pipeline latencies, captures results and strobes o_valid.
module foc_xform_sequencer #(
  parameter int W          = 16,
  parameter int CLARKE_LAT = 2,
  parameter int PARK_LAT   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_trig,
  input  logic         i_abort,
  input  logic [W-1:0] i_ia,
  input  logic [W-1:0] i_ib,
  input  logic [W-1:0] i_theta,
  output logic [W-1:0] o_ia,
  output logic [W-1:0] o_ib,
  output logic [W-1:0] o_phi,
  input  logic [W-1:0] i_alpha,
  input  logic [W-1:0] i_beta,
  input  logic [W-1:0] i_id,
  input  logic [W-1:0] i_iq,
  output logic [W-1:0] o_alpha,
  output logic [W-1:0] o_beta,
  output logic [W-1:0] o_id,
  output logic [W-1:0] o_iq,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_overrun,
  input  logic         i_clr_ovr,
  output logic [7:0]   o_ovr_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CLK_WAIT,
    PRK_WAIT,
    DONE
  } state_t;

  localparam logic [3:0] CLK_LOAD = 4'(CLARKE_LAT - 1);
  localparam logic [3:0] PRK_LOAD = 4'(PARK_LAT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic       busy;
  logic       accept;
  logic       clk_done;
  logic       prk_done;
  logic       ovr_ev;

  assign busy     = (state_q == CLK_WAIT) || (state_q == PRK_WAIT);
  assign accept   = i_trig & i_en & ~i_abort
                  & ((state_q == IDLE) || (state_q == DONE));
  assign clk_done = (state_q == CLK_WAIT) && (cnt_q == 4'd0) && !i_abort;
  assign prk_done = (state_q == PRK_WAIT) && (cnt_q == 4'd0) && !i_abort;
  assign ovr_ev   = i_trig & i_en & busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (accept) state_d = CLK_WAIT;
        CLK_WAIT: if (cnt_q == 4'd0) state_d = PRK_WAIT;
        PRK_WAIT: if (cnt_q == 4'd0) state_d = DONE;
        DONE:     state_d = accept ? CLK_WAIT : IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_valid = 1'b0;
    o_busy  = 1'b0;
    unique case (state_q)
      CLK_WAIT: o_busy  = 1'b1;
      PRK_WAIT: o_busy  = 1'b1;
      DONE:     o_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (i_abort) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= CLK_LOAD;
    end else if (clk_done) begin
      cnt_q <= PRK_LOAD;
    end else if (busy && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Snapshot held at the transform inputs for the whole conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ia  <= '0;
      o_ib  <= '0;
      o_phi <= '0;
    end else if (accept) begin
      o_ia  <= i_ia;
      o_ib  <= i_ib;
      o_phi <= i_theta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_alpha <= '0;
      o_beta  <= '0;
    end else if (clk_done) begin
      o_alpha <= i_alpha;
      o_beta  <= i_beta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_id <= '0;
      o_iq <= '0;
    end else if (prk_done) begin
      o_id <= i_id;
      o_iq <= i_iq;
    end
  end

  // Clear beats a coincident overrun; the count saturates at 255
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overrun <= 1'b0;
      o_ovr_cnt <= 8'd0;
    end else if (i_clr_ovr) begin
      o_overrun <= 1'b0;
      o_ovr_cnt <= 8'd0;
    end else if (ovr_ev) begin
      o_overrun <= 1'b1;
      if (o_ovr_cnt != 8'hFF) o_ovr_cnt <= o_ovr_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_foc_xform_sequencer.sv
// Bench for foc_xform_sequencer: conversion-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_foc_xform_sequencer;

  localparam int W  = 16;
  localparam int CL = 2;
  localparam int PL = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_en, i_trig, i_abort, i_clr_ovr;
  logic [W-1:0] i_ia, i_ib, i_theta;
  logic [W-1:0] o_ia, o_ib, o_phi;
  logic [W-1:0] i_alpha, i_beta, i_id, i_iq;
  logic [W-1:0] o_alpha, o_beta, o_id, o_iq;
  logic         o_valid, o_busy, o_overrun;
  logic [7:0]   o_ovr_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  foc_xform_sequencer #(.W(W), .CLARKE_LAT(CL), .PARK_LAT(PL)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_trig(i_trig),
    .i_abort(i_abort), .i_ia(i_ia), .i_ib(i_ib), .i_theta(i_theta),
    .o_ia(o_ia), .o_ib(o_ib), .o_phi(o_phi),
    .i_alpha(i_alpha), .i_beta(i_beta), .i_id(i_id), .i_iq(i_iq),
    .o_alpha(o_alpha), .o_beta(o_beta), .o_id(o_id), .o_iq(o_iq),
    .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun),
    .i_clr_ovr(i_clr_ovr), .o_ovr_cnt(o_ovr_cnt)
  );

  // Pass-through transforms: clarke output is ready at the capture edge
  // CL edges after the snapshot, park output PL edges after that.
  logic [W-1:0] c_a, c_b;
  logic [W-1:0] p_a [PL];
  logic [W-1:0] p_b [PL];
  always @(posedge clk) begin
    c_a    <= o_ia;
    c_b    <= o_ib;
    p_a[0] <= c_a;
    p_b[0] <= c_b;
    for (int i = 1; i < PL; i++) begin
      p_a[i] <= p_a[i-1];
      p_b[i] <= p_b[i-1];
    end
  end
  assign i_alpha = c_a;
  assign i_beta  = c_b;
  assign i_id    = p_a[PL-1];
  assign i_iq    = p_b[PL-1];

  // Conversion-level model: a countdown of remaining in-flight cycles
  int           m_left;
  int           m_cnt;
  logic         m_valid, m_ovr;
  logic [W-1:0] m_ia, m_ib, m_phi, m_al, m_be, m_id, m_iq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_cnt <= 0; m_valid <= 1'b0; m_ovr <= 1'b0;
      m_ia <= '0; m_ib <= '0; m_phi <= '0;
      m_al <= '0; m_be <= '0; m_id <= '0; m_iq <= '0;
    end else begin
      if (i_clr_ovr) begin
        m_ovr <= 1'b0;
        m_cnt <= 0;
      end else if (m_left > 0 && i_trig && i_en) begin
        m_ovr <= 1'b1;
        m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      m_valid <= 1'b0;
      if (i_abort) begin
        m_left <= 0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == PL + 1) begin
          m_al <= m_ia;
          m_be <= m_ib;
        end
        if (m_left == 1) begin
          m_valid <= 1'b1;
          m_id <= m_ia;
          m_iq <= m_ib;
        end
      end else if (i_trig && i_en) begin
        m_ia <= i_ia; m_ib <= i_ib; m_phi <= i_theta;
        m_left <= CL + PL;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid",   32'(o_valid),   32'(m_valid));
      chk("busy",    32'(o_busy),    32'(m_left > 0));
      chk("overrun", 32'(o_overrun), 32'(m_ovr));
      chk("ovr_cnt", 32'(o_ovr_cnt), 32'(m_cnt));
      chk("ia_hold", 32'(o_ia),      32'(m_ia));
      chk("ib_hold", 32'(o_ib),      32'(m_ib));
      chk("phi",     32'(o_phi),     32'(m_phi));
      chk("alpha",   32'(o_alpha),   32'(m_al));
      chk("beta",    32'(o_beta),    32'(m_be));
      chk("id",      32'(o_id),      32'(m_id));
      chk("iq",      32'(o_iq),      32'(m_iq));
    end
  end

  // Trigger now, then watch n samples; optional extra trigger / abort
  task automatic run(input int ncyc, input int t2, input int ab,
                     input logic en_after, output int v_first,
                     output int v_n, output int b_n);
    v_first = 0; v_n = 0; b_n = 0;
    i_trig = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (o_valid) begin
        if (v_n == 0) v_first = n;
        v_n++;
      end
      if (o_busy) b_n++;
      i_trig  = (n == t2);
      i_abort = (n == ab);
      i_en    = en_after;
    end
    i_trig = 1'b0; i_abort = 1'b0; i_en = 1'b1;
  endtask

  int vf, vn, bn;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_en = 1'b1; i_trig = 1'b0; i_abort = 1'b0;
    i_clr_ovr = 1'b0; i_ia = '0; i_ib = '0; i_theta = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_id",    32'(o_id),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    i_ia = 16'd16384; i_ib = 16'hE000; i_theta = 16'h1234;
    run(12, 0, 0, 1'b1, vf, vn, bn);
    chk("t1_vat",   32'(vf), 32'd9);
    chk("t1_vn",    32'(vn), 32'd1);
    chk("t1_busy",  32'(bn), 32'd8);
    chk("t1_phi",   32'(o_phi), 32'h1234);
    chk("t1_id",    32'(o_id),  32'd16384);
    chk("t1_iq",    32'(o_iq),  32'hE000);
    chk("t1_alpha", 32'(o_alpha), 32'd16384);

    i_ia = 16'd300; i_ib = 16'd400; i_theta = 16'h0010;
    run(14, 3, 0, 1'b1, vf, vn, bn);
    chk("t2_vat",  32'(vf), 32'd9);
    chk("t2_vn",   32'(vn), 32'd1);
    chk("t2_ovr",  32'(o_overrun), 32'd1);
    chk("t2_cnt",  32'(o_ovr_cnt), 32'd1);

    for (int c = 0; c < 50; c++) begin
      i_trig = 1'b1;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        i_trig = (n >= 2 && n <= 7);
      end
      i_trig = 1'b0;
    end
    chk("t3_sat",  32'(o_ovr_cnt), 32'd255);
    chk("t3_ovr",  32'(o_overrun), 32'd1);
    i_clr_ovr = 1'b1;
    @(negedge clk);
    i_clr_ovr = 1'b0;
    chk("t3_clr_ovr", 32'(o_overrun), 32'd0);
    chk("t3_clr_cnt", 32'(o_ovr_cnt), 32'd0);

    i_ia = 16'd100; i_ib = 16'hFF00; i_theta = 16'h0042;
    run(22, 9, 0, 1'b1, vf, vn, bn);
    chk("t4_vat",  32'(vf), 32'd9);
    chk("t4_vn",   32'(vn), 32'd2);
    chk("t4_busy", 32'(bn), 32'd16);
    chk("t4_ovr",  32'(o_overrun), 32'd0);

    i_ia = 16'd777; i_ib = 16'd888; i_theta = 16'h0777;
    run(14, 0, 4, 1'b1, vf, vn, bn);
    chk("t5_vn",   32'(vn), 32'd0);
    chk("t5_busy", 32'(bn), 32'd4);
    chk("t5_id",   32'(o_id), 32'd100);
    chk("t5_iq",   32'(o_iq), 32'hFF00);

    i_ia = 16'd555; i_ib = 16'd666;
    run(12, 0, 0, 1'b0, vf, vn, bn);
    chk("t6_vat",  32'(vf), 32'd9);
    chk("t6_id",   32'(o_id), 32'd555);

    i_en = 1'b0; i_trig = 1'b1;
    @(negedge clk);
    i_trig = 1'b0; i_en = 1'b1;
    @(negedge clk);
    chk("t7_busy", 32'(o_busy), 32'd0);
    i_trig = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_trig = 1'b0; i_abort = 1'b0;
    chk("t8_busy", 32'(o_busy), 32'd0);
    chk("t8_ovr",  32'(o_overrun), 32'd0);

    i_ia = 16'd1234; i_ib = 16'd4321;
    i_trig = 1'b1;
    repeat (5) begin
      @(negedge clk);
      i_trig = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("t9_busy", 32'(o_busy),  32'd0);
    chk("t9_ia",   32'(o_ia),    32'd0);
    chk("t9_id",   32'(o_id),    32'd0);
    chk("t9_al",   32'(o_alpha), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    i_en = 1'b0;
    run(12, 0, 0, 1'b0, vf, vn, bn);
    chk("t9_en0_vn",   32'(vn), 32'd0);
    chk("t9_en0_busy", 32'(bn), 32'd0);
    chk("t9_en0_ia",   32'(o_ia), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/foc_xform_sequencer.md
Name: foc_xform_sequencer

Overview:
- Sequences the free-running clarke and park blocks for one FOC current sample per PWM trigger.
- Snapshots phase currents and rotor angle, then holds them stable at the transform inputs.
- Waits each stage's fixed pipeline latency, then captures id/iq and alpha/beta and emits a one-cycle valid strobe to the downstream PI current loops.
- Detects and counts triggers that arrive while a conversion is still in flight.

Parameters:
- W, 16, data width of currents, angle, alpha/beta, id/iq
- CLARKE_LAT, 2, cycles from stable ia/ib to valid alpha/beta (1..15)
- PARK_LAT, 6, cycles from stable alpha/beta/phi to valid id/iq (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_en  in  1  enable; triggers are accepted only when high
- i_trig  in  1  sample trigger (PWM centre), single-cycle pulse
- i_abort  in  1  synchronous abort of the conversion in flight
- i_ia, i_ib  in  W  signed phase currents from ADC
- i_theta  in  W  unsigned electrical angle
- o_ia, o_ib  out  W  held currents driving clarke.ia/ib
- o_phi  out  W  held angle driving park.phi
- i_alpha, i_beta  in  W  signed clarke outputs
- i_id, i_iq  in  W  signed park outputs
- o_alpha, o_beta  out  W  captured alpha/beta
- o_id, o_iq  out  W  captured id/iq
- o_valid  out  1  one-cycle strobe; o_id/o_iq/o_alpha/o_beta are new
- o_busy  out  1  high while a conversion is in flight
- o_overrun  out  1  sticky; a trigger was lost
- i_clr_ovr  in  1  clears o_overrun and o_ovr_cnt
- o_ovr_cnt  out  8  saturating count of lost triggers

Behaviour:
- Reset (async, rst=1): state IDLE; counter 0; all outputs 0. o_ia/o_ib/o_phi=0.
- FSM states: IDLE, CLK_WAIT, PRK_WAIT, DONE.
- IDLE:
  - Transition on i_trig&i_en at edge k.
  - At that edge: latch o_ia/o_ib/o_phi from inputs; load cnt=CLARKE_LAT-1; go to CLK_WAIT.
- CLK_WAIT:
  - Decrement cnt each cycle.
  - At cnt==0: capture o_alpha/o_beta from i_alpha/i_beta; load cnt=PARK_LAT-1; go to PRK_WAIT.
- PRK_WAIT:
  - Decrement cnt each cycle.
  - At cnt==0: capture o_id/o_iq; set o_valid; go to DONE.
- DONE (one cycle):
  - o_valid=1 only in this state.
  - Go to IDLE, or restart as in IDLE if i_trig&i_en are present (back-to-back, not an overrun).
- Latency: o_valid is high in the cycle after edge k+CLARKE_LAT+PARK_LAT, i.e. 1+CLARKE_LAT+PARK_LAT cycles after the trigger edge (9 at defaults).
- o_busy=1 in CLK_WAIT and PRK_WAIT; 0 in IDLE and DONE.
- o_ia/o_ib/o_phi change only at the trigger-accept edge; held constant otherwise.
- Captured outputs hold until the next capture. They are not cleared on abort.
- Overrun:
  - i_trig while o_busy is ignored for sampling.
  - Sets o_overrun and increments o_ovr_cnt, saturating at 255.
  - If i_clr_ovr coincides with an overrun, the clear wins: both go to 0 and that event is lost.
- i_en deasserted mid-conversion: the conversion completes normally. It only gates new triggers.
- i_abort:
  - Highest priority in any state: next state IDLE, cnt=0, no o_valid that cycle.
  - i_abort with i_trig in IDLE: the trigger is dropped and not counted as an overrun.
- i_trig in IDLE with i_en=0: ignored, not an overrun.
- Arithmetic: none on the data path. cnt is 4 bits; o_ovr_cnt saturates and never wraps.

Test Plan:
- Bench drives i_alpha/i_beta as i_ia/i_ib delayed 2 cycles, and i_id/i_iq as alpha/beta delayed 6 cycles (theta=0 pass-through).
- Reset release, then trigger with ia=16384, ib=-8192, theta=0x1234 -> o_phi=0x1234; o_valid exactly 9 cycles after the trigger edge; o_id=16384, o_iq=-8192; o_busy high for 8 cycles.
- Second trigger 3 cycles after the first -> first result still valid at 9; o_overrun=1, o_ovr_cnt=1; no second o_valid.
- 300 triggers during busy windows, no clear -> o_ovr_cnt=255. Then i_clr_ovr -> o_overrun=0, o_ovr_cnt=0.
- Trigger coincident with the DONE cycle -> accepted; second o_valid 9 cycles later; o_overrun stays 0.
- i_abort 4 cycles after a trigger -> o_busy drops next cycle; no o_valid; o_id/o_iq keep their previous values.
- Async rst pulse mid-PRK_WAIT -> all outputs 0 immediately; i_en=0 with a trigger -> nothing happens.
